// File: rtl/hue_stage1.sv
// Sequential hue divider/offset stage: hue = sector_offset +/- 60*|dividend|/divisor, wrapped to 0..359.
// Optional build macro HUE_ROUND_EN: round the quotient to nearest instead of truncating.
module hue_stage1 #(
  parameter int QW    = 14,
  parameter int HUE_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [8:0]       i_dividend,
  input  logic [8:0]       i_divisor,
  input  logic [1:0]       i_function,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [HUE_W-1:0] o_hue,
  output logic             o_valid,
  output logic             o_overflow
);

  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            sign_q;
  logic [1:0]      func_q;
  logic [8:0]      div_q;
  logic [QW-1:0]   num_q;   // numerator shifts out MSB-first while quotient bits shift in
  logic [QW:0]     rem_q;

  logic            accept;
  logic [8:0]      mag;
  logic [QW-1:0]   num_in;
  logic [QW:0]     rem_sh;
  logic [QW:0]     div_ext;
  logic            fits;
  logic [5:0]      quo;
  logic [HUE_W-1:0] hue_d;

  assign o_ready = (state_q == IDLE);
  assign accept  = o_ready && i_valid && (i_function != 2'd0);

  assign mag = i_dividend[8] ? (~i_dividend + 9'd1) : i_dividend;
`ifdef HUE_ROUND_EN
  assign num_in = QW'(mag) * QW'(60) + QW'(i_divisor >> 1);
`else
  assign num_in = QW'(mag) * QW'(60);
`endif

  assign rem_sh  = {rem_q[QW-1:0], num_q[QW-1]};
  assign div_ext = {{(QW-8){1'b0}}, div_q};
  assign fits    = (rem_sh >= div_ext);

  // A zero divisor marks an achromatic pixel; the divider still runs so latency stays fixed.
  assign quo = (div_q == 9'd0) ? 6'd0 : num_q[5:0];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    hue_d   = '0;
    case (state_q)
      IDLE: if (accept) state_d = DIV;
      DIV:  if (cnt_q == CW'(QW-1)) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (func_q)
      2'd1: hue_d = sign_q ? ((quo == 6'd0) ? '0 : HUE_W'(360) - HUE_W'(quo)) : HUE_W'(quo);
      2'd2: hue_d = sign_q ? HUE_W'(120) - HUE_W'(quo) : HUE_W'(120) + HUE_W'(quo);
      2'd3: hue_d = sign_q ? HUE_W'(240) - HUE_W'(quo) : HUE_W'(240) + HUE_W'(quo);
      default: hue_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: datapath registers are reset too, so an aborted division leaves nothing stale behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      func_q     <= 2'd0;
      div_q      <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      o_hue      <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_valid && !o_ready) o_overflow <= 1'b1;
      case (state_q)
        IDLE: if (accept) begin
          cnt_q  <= '0;
          sign_q <= i_dividend[8];
          func_q <= i_function;
          div_q  <= i_divisor;
          num_q  <= num_in;
          rem_q  <= '0;
        end
        DIV: begin
          cnt_q <= cnt_q + CW'(1);
          num_q <= {num_q[QW-2:0], fits};
          rem_q <= fits ? (rem_sh - div_ext) : rem_sh;
        end
        FIN: begin
          o_hue   <= hue_d;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hue_stage1.sv
// Scoreboard bench for hue_stage1: a driver queues expected hues from an arithmetic model, a monitor checks them.
module tb_hue_stage1;

  localparam int PERIOD = 10;
  localparam int LAT    = 15 * PERIOD + PERIOD / 2;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [8:0] i_dividend = '0;
  logic [8:0] i_divisor = '0;
  logic [1:0] i_function = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [8:0] o_hue;
  logic       o_valid;
  logic       o_overflow;

  typedef struct {
    int  hue;
    time t_acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hue_stage1 dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_function (i_function),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_hue      (o_hue),
    .o_valid    (o_valid),
    .o_overflow (o_overflow)
  );

  always #(PERIOD/2) i_clk = ~i_clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Hue from the sector rules: offset plus or minus the rounded/truncated 60*|x|/d, wrapped to 0..359.
  function automatic int model(input logic [8:0] dvd, input int dvs, input int f);
    int mag, num, q, base, h;
    mag  = dvd[8] ? 512 - int'(dvd) : int'(dvd);
    num  = mag * 60;
`ifdef HUE_ROUND_EN
    num  = num + dvs / 2;
`endif
    q    = (dvs == 0) ? 0 : num / dvs;
    base = (f == 1) ? 0 : (f == 2) ? 120 : 240;
    h    = dvd[8] ? base - q : base + q;
    return (h % 360 + 360) % 360;
  endfunction

  task automatic send(input logic [8:0] dvd, input logic [8:0] dvs, input logic [1:0] f);
    int   budget = 0;
    exp_t e;
    @(negedge i_clk);
    while (!o_ready && budget < 100) begin
      @(negedge i_clk);
      budget++;
    end
    check("ready_wait", o_ready, 1);
    i_dividend = dvd;
    i_divisor  = dvs;
    i_function = f;
    i_valid    = 1'b1;
    @(posedge i_clk);
    e.hue   = model(dvd, int'(dvs), int'(f));
    e.t_acc = $time;
    exp_q.push_back(e);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge i_clk);
      budget++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", o_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hue", o_hue, e.hue);
        check("latency", $time - e.t_acc, LAT);
        check("ready_in_valid_cycle", o_ready, 1);
      end
    end
  end

  initial begin
    #1;
    check("rst_hue", o_hue, 0);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_overflow", o_overflow, 0);
    #(PERIOD + 1) i_rst = 1'b0;

    // directed cases from the sector rules
    send(9'd0,   9'd248, 2'd1);
    send(9'd248, 9'd248, 2'd1);
    send(9'h184, 9'd248, 2'd1);
    send(9'd0,   9'd248, 2'd3);
    send(9'd0,   9'd0,   2'd2);
    send(9'd1,   9'd7,   2'd2);
    send(9'h1ff, 9'd1,   2'd1);
    send(9'h104, 9'd252, 2'd2);
    send(9'd252, 9'd252, 2'd3);
    wait_idle();

    // function 0 in IDLE is ignored
    @(negedge i_clk);
    i_function = 2'd0;
    i_dividend = 9'd5;
    i_divisor  = 9'd9;
    i_valid    = 1'b1;
    repeat (2) @(negedge i_clk);
    i_valid = 1'b0;
    check("f0_ready", o_ready, 1);
    check("f0_overflow", o_overflow, 0);

    // randomized traffic with |dividend| <= divisor
    for (int n = 0; n < 40; n++) begin
      int d, m;
      logic [8:0] dvd;
      d   = $urandom_range(252, 0);
      m   = $urandom_range(d, 0);
      dvd = ($urandom_range(1, 0) == 1) ? 9'(512 - m) : 9'(m);
      send(dvd, 9'(d), 2'($urandom_range(3, 1)));
    end
    wait_idle();
    check("no_overflow_yet", o_overflow, 0);

    // input while busy is dropped and flagged; in-flight result unaffected
    send(9'd100, 9'd200, 2'd2);
    repeat (3) @(negedge i_clk);
    check("busy_ready", o_ready, 0);
    i_dividend = 9'd50;
    i_divisor  = 9'd50;
    i_function = 2'd3;
    i_valid    = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("overflow_set", o_overflow, 1);
    wait_idle();
    check("overflow_sticky", o_overflow, 1);

    // async reset mid-division discards the operation
    send(9'd30, 9'd60, 2'd1);
    repeat (5) @(negedge i_clk);
    #1 i_rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("midrst_hue", o_hue, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_overflow", o_overflow, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (20) @(negedge i_clk);

    send(9'd124, 9'd248, 2'd3);
    wait_idle();
    repeat (20) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hue_stage1.md
Name: hue_stage1

Overview:
- Sequential hue divider and offset stage. Sits directly downstream of the hue pre-stage, which supplies a signed dividend, an unsigned divisor and a sector code.
- Computes hue = sector_offset ± round/trunc(60·|dividend| / divisor) using an iterative restoring divider, wrapped into 0..359.
- Replaces the vendor divider IP with a small, deterministic-latency block.
- Output feeds the colour-range threshold/compare logic.

Parameters:
- QW, 14: numerator width for the restoring divider. 60·252 + 126 < 2^14, so 14 is the minimum. The divider runs QW iterations.
- HUE_W, 9: output hue width, holding 0..359.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous reset, active-high
- i_dividend  input  9  two's-complement dividend, |value| ≤ 252
- i_divisor  input  9  divisor, MSB always 0, value 0..252
- i_function  input  2  sector: 1=red max, 2=green max, 3=blue max, 0=invalid
- i_valid  input  1  input data valid
- o_ready  output  1  block can accept a new input this cycle
- o_hue  output  9  hue in degrees, 0..359
- o_valid  output  1  one-cycle pulse marking a new o_hue
- o_overflow  output  1  sticky flag: input lost because the block was busy

Behaviour:
- Reset (async, i_rst=1): o_hue=0, o_valid=0, o_overflow=0, o_ready=1, state=IDLE. All datapath registers are cleared. An in-flight division is discarded with no output pulse.
- States and transitions:
  - IDLE → DIV: taken on a clock edge with i_valid=1, i_function≠0 and o_ready=1.
  - DIV → FIN: taken after exactly QW iterations (counter 0..QW-1).
  - FIN → IDLE: unconditional, one cycle.
- o_ready is 1 only in IDLE (combinational from state).
- Input with i_valid=1 and i_function=0 in IDLE: ignored, no state change, no overflow.
- Accept edge captures: sign = i_dividend[8]; mag = |i_dividend|; numerator N = mag·60 (+ rounding term, see Optional Feature); divisor D; function F.
- Divider: restoring, one quotient bit per cycle, MSB first. 15-bit partial remainder, compare and subtract against D.
- Quotient Q ≤ 60 by construction (|dividend| ≤ divisor). Q is truncated to 6 bits.
- D=0 (achromatic pixel): the divider still runs QW cycles, but Q is forced to 0. Latency stays uniform.
- FIN computes the hue from F, sign and Q and registers it:
  - F=1: sign=0 → Q; sign=1 → 360-Q, except Q=0 → 0 (never output 360).
  - F=2: 120+Q if sign=0, else 120-Q.
  - F=3: 240+Q if sign=0, else 240-Q.
- At the FIN→IDLE edge: o_hue is updated and o_valid=1 for exactly one cycle.
- o_hue holds its value until the next result.
- Latency: o_valid is high in the cycle beginning QW+1 edges after the accept edge (15 edges for QW=14).
- Throughput: one pixel per QW+2 cycles. The next accept is possible on the edge following the o_valid cycle.
- There is no output backpressure. The downstream block must sample o_hue whenever o_valid=1.
- Overflow: if i_valid=1 while o_ready=0, o_overflow is set to 1 and the input is dropped. o_overflow stays set until reset. The in-flight operation is unaffected.

Optional Feature:
- Macro: HUE_ROUND_EN.
- Defined: N = mag·60 + (D>>1), so Q rounds to nearest. Q ≤ 60 still holds.
- Not defined: N = mag·60, so Q truncates toward zero.
- Latency, ports and all other behaviour are identical in both builds.

Test Plan:
- dividend=0, divisor=248, function=1 → after 15 edges o_hue=0, o_valid pulses 1 cycle, o_ready returns 1 on the next cycle.
- dividend=248, divisor=248, function=1 → o_hue=60. Then dividend=9'h184 (-124), divisor=248, function=1 → o_hue=330.
- dividend=0, divisor=248, function=3 → o_hue=240. Then dividend=0, divisor=0, function=2 → o_hue=120 (Q forced 0), latency unchanged.
- dividend=1, divisor=7, function=2 → o_hue=128 without HUE_ROUND_EN, 129 with it.
- Pulse i_valid 3 cycles after an accept → o_overflow=1 and the first result is unchanged. Assert i_rst mid-DIV → outputs return to reset values immediately, with no o_valid pulse.
